// File: rtl/phase_timer.sv
// phase_timer: answering end of the start/terminal-count handshake.
// It latches one of two durations on an accepted start and counts it down
// on enabled cycles. Completion is signalled with a one-cycle RC pulse.
// Abort cancels the phase silently, and a start seen while busy sets a
// sticky error flag.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         Ck,
    input  logic         Clr,
    input  logic         St,
    input  logic         S,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic         CE,
    input  logic         Abort,
    output logic         Busy,
    output logic         RC,
    output logic [W-1:0] Cnt,
    output logic         Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] cnt_nxt;
    logic         err_nxt;
    logic [W-1:0] dur;

    // State, count and error registers; everything clears asynchronously.
    always_ff @(posedge Ck or negedge Clr) begin
        if (!Clr) begin
            state <= IDLE;
            Cnt   <= '0;
            Err   <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register updates from the
            // same pre-edge values, independent of statement order.
            state <= state_nxt;
            Cnt   <= cnt_nxt;
            Err   <= err_nxt;
        end
    end

    // Next-state, next-count and error logic for the three-state phase FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        cnt_nxt   = Cnt;
        err_nxt   = Err;
        dur       = S ? D1 : D0;

        unique case (state)
            IDLE, DONE: begin
                if (St && !Abort) begin
                    if (dur != '0) begin
                        cnt_nxt   = dur;
                        state_nxt = RUN;
                    end else begin
                        // A zero-length phase still answers with one RC pulse.
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end

            RUN: begin
                // A start while busy is ignored but flagged.
                // Abort and CE are still processed in the same cycle.
                if (St) begin
                    err_nxt = 1'b1;
                end
                if (Abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (CE) begin
                    if (Cnt > ONE) begin
                        cnt_nxt = Cnt - ONE;
                    end else begin
                        // Terminal count: stop at zero, never wrap.
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status outputs are decoded straight from the registered state.
    assign Busy = (state == RUN);
    assign RC   = (state == DONE);

endmodule
